// File: rtl/draw_hp_bar_pkg.sv
// draw_hp_bar_pkg
// Shared constants, colours and types for the health-bar overlay stage.
// No ports: imported by hp_tracker and draw_hp_bar.
package draw_hp_bar_pkg;

    localparam int HP_W = 7;

    localparam logic [HP_W-1:0] HP_MAX  = HP_W'(100);
    localparam logic [HP_W-1:0] HP_LOW  = HP_W'(30);
    localparam logic [HP_W-1:0] HP_CRIT = HP_W'(10);

    localparam logic [11:0] COL_BORDER  = 12'h000;
    localparam logic [11:0] COL_HP_OK   = 12'h0F0;
    localparam logic [11:0] COL_HP_LOW  = 12'hFF0;
    localparam logic [11:0] COL_HP_CRIT = 12'hF00;
    localparam logic [11:0] COL_GHOST   = 12'hF80;
    localparam logic [11:0] COL_FLASH   = 12'hFFF;
    localparam logic [11:0] COL_EMPTY   = 12'h333;

    // One beat of the VGA stream, used to carry the fields through stage 1.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_fields_t;

    // Fill colour depends only on the target HP (the value the bar settles at).
    function automatic logic [11:0] hp_colour(input logic [HP_W-1:0] hp);
        if (hp > HP_LOW) begin
            return COL_HP_OK;
        end else if (hp > HP_CRIT) begin
            return COL_HP_LOW;
        end else begin
            return COL_HP_CRIT;
        end
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if
// VGA stream bundle passed between pipeline stages.
// Fields: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0].
// Modports: rx (stage input), tx (stage output).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport rx (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport tx (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/hp_tracker.sv
// hp_tracker
// Per-player HP state for the health bar: clamps the incoming HP into a
// per-frame target, drains the displayed HP one unit per frame toward it,
// and runs the damage flash counter.
// Ports:
//   clk60MHz     in   system clock
//   rst          in   async reset, active low
//   frame_tick   in   one-cycle pulse per frame
//   hp_in        in   raw HP from game logic (0..127, nominal 0..100)
//   tgt          out  clamped HP captured at the last tick
//   disp         out  HP currently drawn (>= tgt)
//   flash_active out  damage segment is in its flash window
module hp_tracker
    import draw_hp_bar_pkg::*;
#(
    parameter int FLASH_FRAMES = 30
) (
    input  logic            clk60MHz,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic [HP_W-1:0] hp_in,
    output logic [HP_W-1:0] tgt,
    output logic [HP_W-1:0] disp,
    output logic            flash_active
);

    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0] FLASH_RELOAD = FW'(FLASH_FRAMES);

    logic [HP_W-1:0] tgt_new;
    logic [FW-1:0]   flash_cnt;

    // Out-of-range HP values are treated as full health.
    always_comb begin
        tgt_new = (hp_in > HP_MAX) ? HP_MAX : hp_in;
    end

    // Everything moves only on a frame tick, so the bar is stable for a whole
    // frame. The drain compares against the target captured on this same tick;
    // a drop in target is a fresh hit and restarts the flash window, while a
    // rise (heal / new game) snaps the display up and kills the flash.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            tgt       <= HP_MAX;
            disp      <= HP_MAX;
            flash_cnt <= '0;
        end else if (frame_tick) begin
            tgt <= tgt_new;
            if (disp > tgt_new) begin
                disp <= disp - HP_W'(1);
                if (tgt_new < tgt) begin
                    flash_cnt <= FLASH_RELOAD;
                end else if (flash_cnt != '0) begin
                    flash_cnt <= flash_cnt - FW'(1);
                end
            end else if (disp < tgt_new) begin
                disp      <= tgt_new;
                flash_cnt <= '0;
            end else if (flash_cnt != '0) begin
                flash_cnt <= flash_cnt - FW'(1);
            end
        end
    end

    always_comb begin
        flash_active = (flash_cnt != '0);
    end

endmodule

// File: rtl/draw_hp_bar.sv
// draw_hp_bar
// VGA pipeline stage that overlays two health bars (player 1 left, filling
// left to right; player 2 right, filling right to left) with a draining,
// flashing damage segment. Fixed 2-cycle latency on every field.
// Ports:
//   clk60MHz    in   system clock
//   rst         in   async reset, active low
//   hp_player1  in   player-1 HP
//   hp_player2  in   player-2 HP
//   in          in   VGA stream (vga_if.rx)
//   out         out  VGA stream delayed 2 cycles, rgb possibly overlaid
module draw_hp_bar
    import draw_hp_bar_pkg::*;
#(
    parameter int BAR1_X       = 40,
    parameter int BAR2_X       = 560,
    parameter int BAR_Y        = 20,
    parameter int BAR_H        = 16,
    parameter int BAR_SCALE    = 2,
    parameter int FLASH_FRAMES = 30
) (
    input  logic            clk60MHz,
    input  logic            rst,
    input  logic [HP_W-1:0] hp_player1,
    input  logic [HP_W-1:0] hp_player2,
    vga_if.rx               in,
    vga_if.tx               out
);

    localparam logic [10:0] X1_L = 11'(BAR1_X);
    localparam logic [10:0] X1_R = 11'(BAR1_X + 201);
    localparam logic [10:0] X2_L = 11'(BAR2_X);
    localparam logic [10:0] X2_R = 11'(BAR2_X + 201);
    localparam logic [10:0] Y_T  = 11'(BAR_Y);
    localparam logic [10:0] Y_B  = 11'(BAR_Y + BAR_H - 1);
    localparam logic [8:0]  OFF1_BASE = 9'(BAR1_X + 1);
    localparam logic [8:0]  OFF2_BASE = 9'(BAR2_X + 200);

    logic            vblnk_d;
    logic            seen;
    logic            frame_tick;
    logic [7:0]      frame_cnt;

    logic [HP_W-1:0] tgt1, tgt2, disp1, disp2;
    logic            flash1, flash2;

    logic            hit1, hit2, border_next;
    logic [8:0]      off_next;

    vga_fields_t     s1_vid;
    logic            s1_frame1, s1_frame2, s1_border;
    logic [8:0]      s1_off;

    logic [HP_W-1:0] tgt_sel, disp_sel;
    logic            flash_sel;
    logic [8:0]      fill_len, ghost_len;
    logic [11:0]     rgb_next;

    // Frame tick on the rising edge of vblnk. 'seen' makes sure the first
    // sample after reset only sets up the history, so a vblnk that was
    // already high when reset released is not mistaken for an edge.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            vblnk_d   <= 1'b0;
            seen      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vblnk_d <= in.vblnk;
            seen    <= 1'b1;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        frame_tick = seen && in.vblnk && !vblnk_d;
    end

    hp_tracker #(.FLASH_FRAMES(FLASH_FRAMES)) u_track1 (
        .clk60MHz     (clk60MHz),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .hp_in        (hp_player1),
        .tgt          (tgt1),
        .disp         (disp1),
        .flash_active (flash1)
    );

    hp_tracker #(.FLASH_FRAMES(FLASH_FRAMES)) u_track2 (
        .clk60MHz     (clk60MHz),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .hp_in        (hp_player2),
        .tgt          (tgt2),
        .disp         (disp2),
        .flash_active (flash2)
    );

    // Region decode. The fill offset is computed modulo 512; inside the
    // interior it is always 0..199, and the border columns where it wraps
    // are painted by the border rule before the offset is ever looked at.
    always_comb begin
        hit1 = (in.vcount >= Y_T) && (in.vcount <= Y_B)
            && (in.hcount >= X1_L) && (in.hcount <= X1_R);
        hit2 = (in.vcount >= Y_T) && (in.vcount <= Y_B)
            && (in.hcount >= X2_L) && (in.hcount <= X2_R);
        border_next = (hit1 || hit2)
            && ((in.hcount == X1_L) || (in.hcount == X1_R)
             || (in.hcount == X2_L) || (in.hcount == X2_R)
             || (in.vcount == Y_T)  || (in.vcount == Y_B));
        off_next = hit2 ? (OFF2_BASE - 9'(in.hcount))
                        : (9'(in.hcount) - OFF1_BASE);
    end

    // Stage 1: register the stream beat and its region flags.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            s1_vid    <= '0;
            s1_frame1 <= 1'b0;
            s1_frame2 <= 1'b0;
            s1_border <= 1'b0;
            s1_off    <= '0;
        end else begin
            s1_vid    <= '{hcount: in.hcount, vcount: in.vcount,
                           hsync: in.hsync, vsync: in.vsync,
                           hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};
            s1_frame1 <= hit1;
            s1_frame2 <= hit2;
            s1_border <= border_next;
            s1_off    <= off_next;
        end
    end

    // Stage 2 colour selection. HP state is only updated on a vblnk edge, so
    // every visible pixel of a frame sees the same tgt/disp/flash values.
    always_comb begin
        tgt_sel   = s1_frame2 ? tgt2   : tgt1;
        disp_sel  = s1_frame2 ? disp2  : disp1;
        flash_sel = s1_frame2 ? flash2 : flash1;
        fill_len  = 9'(tgt_sel)  * 9'(BAR_SCALE);
        ghost_len = 9'(disp_sel) * 9'(BAR_SCALE);
        rgb_next  = s1_vid.rgb;
        if (!s1_vid.hblnk && !s1_vid.vblnk && (s1_frame1 || s1_frame2)) begin
            if (s1_border) begin
                rgb_next = COL_BORDER;
            end else if (s1_off < fill_len) begin
                rgb_next = hp_colour(tgt_sel);
            end else if (s1_off < ghost_len) begin
                rgb_next = (flash_sel && frame_cnt[2]) ? COL_FLASH : COL_GHOST;
            end else begin
                rgb_next = COL_EMPTY;
            end
        end
    end

    // Output register: second pipeline stage.
    always_ff @(posedge clk60MHz or negedge rst) begin
        if (!rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= s1_vid.hcount;
            out.vcount <= s1_vid.vcount;
            out.hsync  <= s1_vid.hsync;
            out.vsync  <= s1_vid.vsync;
            out.hblnk  <= s1_vid.hblnk;
            out.vblnk  <= s1_vid.vblnk;
            out.rgb    <= rgb_next;
        end
    end

endmodule
